// File: rtl/gfx256_pkg.sv
// gfx256_pkg
// Shared definitions for the 256-bit pixel sequencer:
//   - sequencer state encoding
//   - memory line geometry
//   - color-depth encoding and per-pixel byte-enable helpers
package gfx256_pkg;

  localparam int LINE_BYTES = 32;

  // color_depth encoding
  localparam logic [1:0] CD_8BPP  = 2'd0;
  localparam logic [1:0] CD_16BPP = 2'd1;
  localparam logic [1:0] CD_24BPP = 2'd2;
  localparam logic [1:0] CD_32BPP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  // Byte enables of a pixel relative to its own first byte.
  function automatic logic [3:0] pixel_byte_mask(input logic [1:0] depth);
    logic [3:0] mask;
    case (depth)
      CD_8BPP:  mask = 4'b0001;
      CD_16BPP: mask = 4'b0011;
      CD_24BPP: mask = 4'b0111;
      default:  mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Line byte enables of a pixel; bytes beyond the line end fall off the top.
  function automatic logic [LINE_BYTES-1:0] pixel_sel(input logic [1:0] depth,
                                                      input logic [4:0] byte_ofs);
    return {28'd0, pixel_byte_mask(depth)} << byte_ofs;
  endfunction

endpackage

// File: rtl/color_to_memory256.sv
// color_to_memory256
// Places one pixel color into its byte lanes of a 256-bit memory line.
// Ports:
//   color_depth_i  pixel format (gfx256_pkg CD_* encoding)
//   adr_i          byte offset of the pixel inside the line
//   color_i        pixel color, byte 0 at the lowest address
//   sel_o          line byte enables of the pixel
//   dat_o          line data with the pixel in place, other lanes zero
module color_to_memory256
  import gfx256_pkg::*;
(
  input  logic [1:0]   color_depth_i,
  input  logic [4:0]   adr_i,
  input  logic [31:0]  color_i,
  output logic [31:0]  sel_o,
  output logic [255:0] dat_o
);

  logic [3:0]  byte_mask;
  logic [31:0] color_masked;

  assign byte_mask = pixel_byte_mask(color_depth_i);

  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign color_masked[8*gi +: 8] = byte_mask[gi] ? color_i[8*gi +: 8] : 8'h00;
  end

  assign sel_o = pixel_sel(color_depth_i, adr_i);
  // Shifting in the full line width drops bytes that would land past byte 31.
  assign dat_o = {224'd0, color_masked} << {adr_i, 3'b000};

endmodule

// File: rtl/gfx256_wcbuf.sv
// gfx256_wcbuf
// One-line write-combining buffer.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   merge_i         merge sel_i/dat_i into the buffer, adopting line_i
//   line_i          line address of the merging pixel
//   sel_i, dat_i    pixel byte enables and lane-aligned data
//   clear_i         mark the buffer clean (after its line reached memory)
//   cmp_line_i      line address to compare against the buffered line
//   hit_o           buffer dirty and holding cmp_line_i
//   dirty_o         any byte enable set
//   line_o, sel_o, dat_o  buffer contents
module gfx256_wcbuf #(
  parameter int LINE_W = 27
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              merge_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic [31:0]       sel_i,
  input  logic [255:0]      dat_i,
  input  logic              clear_i,
  input  logic [LINE_W-1:0] cmp_line_i,
  output logic              hit_o,
  output logic              dirty_o,
  output logic [LINE_W-1:0] line_o,
  output logic [31:0]       sel_o,
  output logic [255:0]      dat_o
);

  logic [LINE_W-1:0] line_q, line_d;
  logic [31:0]       sel_q, sel_d;
  logic [255:0]      dat_q, dat_d;

  // Later writes overwrite only the bytes they enable.
  for (genvar gi = 0; gi < 32; gi++) begin : g_merge
    assign dat_d[8*gi +: 8] = (merge_i && sel_i[gi]) ? dat_i[8*gi +: 8] : dat_q[8*gi +: 8];
  end

  always_comb begin
    line_d = line_q;
    sel_d  = sel_q;
    if (clear_i) begin
      sel_d = '0;
    end else if (merge_i) begin
      // Merges only happen when clean or on the same line, so adopting line_i is safe.
      line_d = line_i;
      sel_d  = sel_q | sel_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
      sel_q  <= '0;
      dat_q  <= '0;
    end else begin
      line_q <= line_d;
      sel_q  <= sel_d;
      dat_q  <= dat_d;
    end
  end

  assign dirty_o = |sel_q;
  assign hit_o   = dirty_o && (line_q == cmp_line_i);
  assign line_o  = line_q;
  assign sel_o   = sel_q;
  assign dat_o   = dat_q;

endmodule

// File: rtl/memory_to_color256.sv
// memory_to_color256
// Extracts one pixel color from a 256-bit memory line.
// Ports:
//   color_depth_i  pixel format (gfx256_pkg CD_* encoding)
//   adr_i          byte offset of the pixel inside the line
//   dat_i          line data
//   color_o        pixel color, unused upper bytes zero
module memory_to_color256
  import gfx256_pkg::*;
(
  input  logic [1:0]   color_depth_i,
  input  logic [4:0]   adr_i,
  input  logic [255:0] dat_i,
  output logic [31:0]  color_o
);

  logic [255:0] shifted;
  logic [3:0]   byte_mask;

  // Right shift zero-fills, so bytes past the line end read as zero.
  assign shifted   = dat_i >> {adr_i, 3'b000};
  assign byte_mask = pixel_byte_mask(color_depth_i);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign color_o[8*gi +: 8] = byte_mask[gi] ? shifted[8*gi +: 8] : 8'h00;
  end

endmodule

// File: rtl/gfx256_pixel_sequencer.sv
// gfx256_pixel_sequencer
// Sequences single-pixel reads/writes onto a 256-bit line-wide memory master.
// Writes combine in a one-line buffer; reads hitting the dirty buffered line
// flush it first so reads always observe every accepted write.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   color_depth_i          0=8, 1=16, 2=24, 3=32 bpp (change only while idle_o)
//   wr_valid_i/wr_ready_o  pixel write handshake, wr_adr_i / wr_color_i
//   rd_valid_i/rd_ready_o  pixel read handshake, rd_adr_i
//   rd_color_o, rd_done_o  read result and its one-cycle completion pulse
//   flush_i                push a dirty buffer to memory
//   idle_o                 idle with a clean buffer
//   m_*                    memory master (cyc/we/adr/sel/dat out, ack/dat in)
module gfx256_pixel_sequencer
  import gfx256_pkg::*;
#(
  parameter int ADR_W         = 32,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       color_depth_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [ADR_W-1:0] wr_adr_i,
  input  logic [31:0]      wr_color_i,
  input  logic             rd_valid_i,
  output logic             rd_ready_o,
  input  logic [ADR_W-1:0] rd_adr_i,
  output logic [31:0]      rd_color_o,
  output logic             rd_done_o,
  input  logic             flush_i,
  output logic             idle_o,
  output logic             m_cyc_o,
  output logic             m_we_o,
  output logic [ADR_W-6:0] m_adr_o,
  output logic [31:0]      m_sel_o,
  output logic [255:0]     m_dat_o,
  input  logic             m_ack_i,
  input  logic [255:0]     m_dat_i
);

  localparam int         LINE_W       = ADR_W - 5;
  localparam logic [7:0] TIMEOUT_LAST = 8'(FLUSH_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                m_cyc_q, m_cyc_d;
  logic                m_we_q, m_we_d;
  logic [LINE_W-1:0]   m_adr_q, m_adr_d;
  logic [31:0]         m_sel_q, m_sel_d;
  logic [255:0]        m_dat_q, m_dat_d;
  logic [31:0]         rd_color_q, rd_color_d;
  logic                rd_done_q, rd_done_d;
  logic [7:0]          timer_q, timer_d;

  logic [LINE_W-1:0]   wr_line, rd_line, cmp_line;
  logic [31:0]         wr_sel, rd_sel, rd_color_unpacked;
  logic [255:0]        wr_dat;
  logic                buf_merge, buf_clear, buf_hit, buf_dirty, start_flush, bus_ack;
  logic [LINE_W-1:0]   buf_line;
  logic [31:0]         buf_sel;
  logic [255:0]        buf_dat;

  assign wr_line = wr_adr_i[ADR_W-1:5];
  assign rd_line = rd_adr_i[ADR_W-1:5];
  assign rd_sel  = pixel_sel(color_depth_i, rd_adr_i[4:0]);
  // Acks are only meaningful while our own bus cycle is open.
  assign bus_ack = m_ack_i && m_cyc_q;
  // Reads outrank writes in IDLE, so compare against whichever will be acted on.
  assign cmp_line = rd_valid_i ? rd_line : wr_line;

  color_to_memory256 u_wr_pack (
    .color_depth_i (color_depth_i),
    .adr_i         (wr_adr_i[4:0]),
    .color_i       (wr_color_i),
    .sel_o         (wr_sel),
    .dat_o         (wr_dat)
  );

  memory_to_color256 u_rd_unpack (
    .color_depth_i (color_depth_i),
    .adr_i         (rd_adr_i[4:0]),
    .dat_i         (m_dat_i),
    .color_o       (rd_color_unpacked)
  );

  gfx256_wcbuf #(.LINE_W(LINE_W)) u_wcbuf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .merge_i    (buf_merge),
    .line_i     (wr_line),
    .sel_i      (wr_sel),
    .dat_i      (wr_dat),
    .clear_i    (buf_clear),
    .cmp_line_i (cmp_line),
    .hit_o      (buf_hit),
    .dirty_o    (buf_dirty),
    .line_o     (buf_line),
    .sel_o      (buf_sel),
    .dat_o      (buf_dat)
  );

  always_comb begin
    state_d     = state_q;
    m_cyc_d     = m_cyc_q;
    m_we_d      = m_we_q;
    m_adr_d     = m_adr_q;
    m_sel_d     = m_sel_q;
    m_dat_d     = m_dat_q;
    rd_color_d  = rd_color_q;
    rd_done_d   = 1'b0;
    timer_d     = timer_q;
    buf_merge   = 1'b0;
    buf_clear   = 1'b0;
    start_flush = 1'b0;
    wr_ready_o  = 1'b0;
    rd_ready_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (buf_dirty && (flush_i || timer_q == TIMEOUT_LAST)) begin
          start_flush = 1'b1;
        end else if (rd_valid_i) begin
          if (buf_hit) begin
            start_flush = 1'b1;
          end else begin
            state_d = ST_READ;
            m_cyc_d = 1'b1;
            m_we_d  = 1'b0;
            m_adr_d = rd_line;
            m_sel_d = rd_sel;
          end
        end else if (wr_valid_i) begin
          if (!buf_dirty || buf_hit) begin
            buf_merge  = 1'b1;
            wr_ready_o = 1'b1;
          end else begin
            start_flush = 1'b1;
          end
        end

        if (buf_merge) begin
          timer_d = '0;
        end else if (buf_dirty && timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end

      ST_FLUSH: begin
        if (bus_ack) begin
          buf_clear = 1'b1;
          timer_d   = '0;
          m_cyc_d   = 1'b0;
          m_we_d    = 1'b0;
          m_sel_d   = '0;
          state_d   = ST_IDLE;
        end
      end

      ST_READ: begin
        if (bus_ack) begin
          rd_ready_o = 1'b1;
          rd_color_d = rd_color_unpacked;
          rd_done_d  = 1'b1;
          m_cyc_d    = 1'b0;
          m_sel_d    = '0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The bus image of the buffer is captured once and held until ack.
    if (start_flush) begin
      state_d = ST_FLUSH;
      m_cyc_d = 1'b1;
      m_we_d  = 1'b1;
      m_adr_d = buf_line;
      m_sel_d = buf_sel;
      m_dat_d = buf_dat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      m_cyc_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_adr_q    <= '0;
      m_sel_q    <= '0;
      m_dat_q    <= '0;
      rd_color_q <= '0;
      rd_done_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      m_cyc_q    <= m_cyc_d;
      m_we_q     <= m_we_d;
      m_adr_q    <= m_adr_d;
      m_sel_q    <= m_sel_d;
      m_dat_q    <= m_dat_d;
      rd_color_q <= rd_color_d;
      rd_done_q  <= rd_done_d;
      timer_q    <= timer_d;
    end
  end

  assign idle_o     = (state_q == ST_IDLE) && !buf_dirty;
  assign m_cyc_o    = m_cyc_q;
  assign m_we_o     = m_we_q;
  assign m_adr_o    = m_adr_q;
  assign m_sel_o    = m_sel_q;
  assign m_dat_o    = m_dat_q;
  assign rd_color_o = rd_color_q;
  assign rd_done_o  = rd_done_q;

endmodule

// File: tb/tb_gfx256_pixel_sequencer.sv
// Directed testbench for gfx256_pixel_sequencer with a small memory responder.
module tb_gfx256_pixel_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   color_depth = 2'd3;
  logic         wr_valid = 1'b0;
  logic         wr_ready_o;
  logic [31:0]  wr_adr = '0;
  logic [31:0]  wr_color = '0;
  logic         rd_valid = 1'b0;
  logic         rd_ready_o;
  logic [31:0]  rd_adr = '0;
  logic [31:0]  rd_color_o;
  logic         rd_done_o;
  logic         flush = 1'b0;
  logic         idle_o;
  logic         m_cyc_o, m_we_o;
  logic [26:0]  m_adr_o;
  logic [31:0]  m_sel_o;
  logic [255:0] m_dat_o;
  logic         m_ack = 1'b0;
  logic [255:0] m_dat_in = '0;

  int checks = 0;
  int errors = 0;
  int wait_cnt = 0;
  int done_cnt = 0;
  int cyc_cnt = 0;
  logic ack_block = 1'b0;

  logic [255:0] mem [logic [26:0]];
  logic         op_we  [$];
  logic [26:0]  op_adr [$];
  logic [31:0]  op_sel [$];
  logic [255:0] op_dat [$];
  logic [255:0] cur;

  always #5 clk = ~clk;

  gfx256_pixel_sequencer #(.ADR_W(32), .FLUSH_TIMEOUT(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .color_depth_i (color_depth),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready_o),
    .wr_adr_i      (wr_adr),
    .wr_color_i    (wr_color),
    .rd_valid_i    (rd_valid),
    .rd_ready_o    (rd_ready_o),
    .rd_adr_i      (rd_adr),
    .rd_color_o    (rd_color_o),
    .rd_done_o     (rd_done_o),
    .flush_i       (flush),
    .idle_o        (idle_o),
    .m_cyc_o       (m_cyc_o),
    .m_we_o        (m_we_o),
    .m_adr_o       (m_adr_o),
    .m_sel_o       (m_sel_o),
    .m_dat_o       (m_dat_o),
    .m_ack_i       (m_ack),
    .m_dat_i       (m_dat_in)
  );

  // Memory responder: acks on the second falling edge of an open cycle.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack = 1'b0;
      wait_cnt = 0;
    end else if (m_ack) begin
      m_ack = 1'b0;
      wait_cnt = 0;
    end else if (m_cyc_o && !ack_block) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt == 2) begin
        m_ack = 1'b1;
        cur = mem.exists(m_adr_o) ? mem[m_adr_o] : '0;
        if (m_we_o) begin
          for (int b = 0; b < 32; b++)
            if (m_sel_o[b]) cur[8*b +: 8] = m_dat_o[8*b +: 8];
          mem[m_adr_o] = cur;
        end else begin
          m_dat_in = cur;
        end
        op_we.push_back(m_we_o);
        op_adr.push_back(m_adr_o);
        op_sel.push_back(m_sel_o);
        op_dat.push_back(m_dat_o);
        $display("BUS %s adr=%0h sel=%08h dat[63:0]=%016h", m_we_o ? "WR" : "RD",
                 m_adr_o, m_sel_o, m_dat_o[63:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rd_done_o) done_cnt = done_cnt + 1;
    if (m_cyc_o) cyc_cnt = cyc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] c,
                          output int ops_at_accept, output int stalls);
    int n;
    n = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_adr = a; wr_color = c;
    #1;
    while (!wr_ready_o && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("wr_accept_in_time", n < 200, 1);
    ops_at_accept = op_we.size();
    stalls = n;
    $display("WR adr=%08h color=%08h stalls=%0d", a, c, n);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  // Returns on the falling edge after rd_ready_o, where rd_done_o is expected.
  task automatic do_read(input logic [31:0] a);
    int n;
    n = 0;
    @(negedge clk);
    rd_valid = 1'b1; rd_adr = a;
    #1;
    while (!rd_ready_o && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("rd_ready_in_time", n < 200, 1);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    @(negedge clk);
    $display("RD adr=%08h color=%08h done=%0d", a, rd_color_o, rd_done_o);
  endtask

  task automatic wait_ops(input int target);
    int n;
    n = 0;
    while (op_we.size() < target && n < 200) begin
      @(negedge clk); n++;
    end
    chk("bus_op_in_time", op_we.size() >= target, 1);
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  initial begin
    int base, acc, st, k, d0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m_cyc", m_cyc_o, 0);
    chk("rst_m_we", m_we_o, 0);
    chk("rst_m_adr", m_adr_o, 0);
    chk("rst_m_sel", m_sel_o, 0);
    chk("rst_m_dat", m_dat_o, 0);
    chk("rst_rd_color", rd_color_o, 0);
    chk("rst_rd_done", rd_done_o, 0);
    chk("rst_idle", idle_o, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_rd_ready", rd_ready_o, 0);

    // 1: 32 bpp combining, timeout flush
    color_depth = 2'd3;
    base = op_we.size();
    do_write(32'h1000, 32'hAABBCCDD, acc, st);
    do_write(32'h1004, 32'h11223344, acc, st);
    chk("t1_not_idle", idle_o, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!m_cyc_o && k < 40);
    chk("t1_timeout_delay", k, 17);
    chk("t1_we", m_we_o, 1);
    wait_ops(base + 1);
    chk("t1_adr", op_adr[base], 27'h80);
    chk("t1_sel", op_sel[base], 32'h000000FF);
    chk("t1_dat", op_dat[base][63:0], 64'h11223344AABBCCDD);
    repeat (3) @(negedge clk);
    chk("t1_single_op", op_we.size(), base + 1);
    chk("t1_idle_after", idle_o, 1);

    // 2: 8 bpp, conflicting line forces flush before acceptance
    color_depth = 2'd0;
    base = op_we.size();
    do_write(32'h1000, 32'h0000005A, acc, st);
    do_write(32'h2000, 32'h00000077, acc, st);
    chk("t2_stalled", st != 0, 1);
    chk("t2_flush_before_accept", acc, base + 1);
    chk("t2_adr", op_adr[base], 27'h80);
    chk("t2_sel", op_sel[base], 32'h00000001);
    chk("t2_dat", op_dat[base][7:0], 8'h5A);
    pulse_flush();
    wait_ops(base + 2);
    chk("t2_adr2", op_adr[base+1], 27'h100);
    chk("t2_sel2", op_sel[base+1], 32'h00000001);

    // 3: read hitting the dirty line flushes first
    repeat (3) @(negedge clk);
    color_depth = 2'd1;
    base = op_we.size();
    d0 = done_cnt;
    do_write(32'h1010, 32'h0000BEEF, acc, st);
    do_read(32'h1010);
    chk("t3_rd_done", rd_done_o, 1);
    chk("t3_rd_color", rd_color_o, 32'h0000BEEF);
    chk("t3_first_is_write", op_we[base], 1);
    chk("t3_flush_sel", op_sel[base], 32'h00030000);
    chk("t3_then_read", op_we[base+1], 0);
    chk("t3_read_sel", op_sel[base+1], 32'h00030000);
    repeat (3) @(negedge clk);
    chk("t3_one_done_pulse", done_cnt - d0, 1);
    chk("t3_color_held", rd_color_o, 32'h0000BEEF);

    // 4: 24 bpp at byte 30 drops the third byte
    color_depth = 2'd2;
    base = op_we.size();
    do_write(32'h101E, 32'h00CCDDEE, acc, st);
    pulse_flush();
    wait_ops(base + 1);
    chk("t4_sel", op_sel[base], 32'hC0000000);
    chk("t4_dat_hi", op_dat[base][255:240], 16'hDDEE);
    repeat (2) @(negedge clk);
    do_read(32'h101E);
    chk("t4_rd_color", rd_color_o, 32'h0000DDEE);

    // 5: read and write together on a clean buffer, read wins
    repeat (2) @(negedge clk);
    color_depth = 2'd3;
    base = op_we.size();
    @(negedge clk);
    rd_valid = 1'b1; rd_adr = 32'h2000;
    wr_valid = 1'b1; wr_adr = 32'h3000; wr_color = 32'h12345678;
    #1;
    chk("t5_wr_held_off", wr_ready_o, 0);
    k = 0; st = 0;
    while (!rd_ready_o && k < 200) begin
      @(negedge clk); #1; k++;
      if (wr_ready_o) st = 1;
    end
    chk("t5_rd_ready_in_time", k < 200, 1);
    chk("t5_no_early_write", st, 0);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    @(negedge clk);
    chk("t5_rd_done", rd_done_o, 1);
    chk("t5_wr_accepted_now", wr_ready_o, 1);
    chk("t5_rd_color", rd_color_o, 32'h00000077);
    chk("t5_read_op", op_we[base], 0);
    chk("t5_read_adr", op_adr[base], 27'h100);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    pulse_flush();
    wait_ops(base + 2);
    chk("t5_wr_adr", op_adr[base+1], 27'h180);
    chk("t5_wr_dat", op_dat[base+1][31:0], 32'h12345678);

    // 6: reset during FLUSH before ack
    repeat (3) @(negedge clk);
    base = op_we.size();
    ack_block = 1'b1;
    do_write(32'h4000, 32'hCAFEF00D, acc, st);
    pulse_flush();
    k = 0;
    while (!m_cyc_o && k < 20) begin @(negedge clk); k++; end
    chk("t6_flush_started", m_cyc_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_cyc_drop_async", m_cyc_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_block = 1'b0;
    @(negedge clk);
    chk("t6_idle_after", idle_o, 1);
    cyc_cnt = 0;
    pulse_flush();
    repeat (10) @(negedge clk);
    chk("t6_no_bus_cycle", cyc_cnt, 0);
    chk("t6_no_bus_op", op_we.size(), base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout obs=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
